no_op_mem_responder: RTL and testbench

- Memory-side responder for the no_op CPU read handshake: mem_address, mem_read, mem_value, mem_ready.
- Holds a synchronous word array and returns data after a programmable latency using a four-phase handshake.
- Has a side-band load port so benches can preload program/data words.
- Replaces the zero-latency combinational memory model wherever cycle-accurate stalls are needed.

---
 rtl/no_op_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_no_op_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/no_op_mem_responder.sv
// no_op_mem_responder
//   Memory-side responder for the no_op CPU read handshake. Holds a word
//   array (not reset) and answers a four-phase read request after LATENCY
//   clock edges. A side-band load port lets a bench preload words.
//
// Ports:
//   clock        - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   mem_address  - read address, sampled only when a request is accepted
//   mem_read     - read request level (four-phase)
//   mem_value    - registered read data, valid while mem_ready is high
//   mem_ready    - registered data-valid / acknowledge
//   mem_error    - registered, high with mem_ready for out-of-range addresses
//   load_en      - side-band write strobe
//   load_addr    - side-band write address
//   load_data    - side-band write data
`ifndef ARCH_SIZE
`define ARCH_SIZE 15
`endif

module no_op_mem_responder #(
  parameter int WIDTH      = `ARCH_SIZE + 1,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      mem_address,
  input  logic                  mem_read,
  output logic [WIDTH-1:0]      mem_value,
  output logic                  mem_ready,
  output logic                  mem_error,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [WIDTH-1:0]      load_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] READY   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // The counter is four bits wide, so only latencies 0..15 can be honoured.
  generate
    if (LATENCY < 0 || LATENCY > 15) begin : gBadLatency
      $error("no_op_mem_responder: LATENCY must be in 0..15");
    end
  endgenerate

  // Counter preload: the acceptance edge itself accounts for one edge.
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  // Address bits at or above DEPTH_LOG2 select nothing in the array.
  localparam logic [WIDTH-1:0] HI_MASK =
    ~WIDTH'((64'd1 << DEPTH_LOG2) - 64'd1);

  logic [WIDTH-1:0] memArray [0:(2**DEPTH_LOG2)-1];

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q,   cnt_d;
  logic [WIDTH-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  logic                  enterReady;
  logic [WIDTH-1:0]      enterAddr;
  logic [DEPTH_LOG2-1:0] enterIdx;
  logic                  outOfRange;

  // Side-band writes happen in any state; contents survive reset.
  always_ff @(posedge clock) begin
    if (load_en) begin
      memArray[load_addr] <= load_data;
    end
  end

  assign enterIdx   = enterAddr[DEPTH_LOG2-1:0];
  assign outOfRange = |(enterAddr & HI_MASK);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    value_d    = value_q;
    ready_d    = ready_q;
    error_d    = error_q;
    enterReady = 1'b0;
    enterAddr  = addr_q;

    case (state_q)
      IDLE: begin
        if (mem_read) begin
          addr_d = mem_address;
          if (LATENCY == 0) begin
            // Zero latency answers on the acceptance edge, so the live
            // address is used since addr_q is only being loaded now.
            enterReady = 1'b1;
            enterAddr  = mem_address;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!mem_read) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          enterReady = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: begin
        if (!mem_read) begin
          state_d = RELEASE;
          ready_d = 1'b0;
          error_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A load hitting the same word on the entry edge wins (write-first).
    if (enterReady) begin
      state_d = READY;
      ready_d = 1'b1;
      error_d = outOfRange;
      if (outOfRange) begin
        value_d = '0;
      end else if (load_en && (load_addr == enterIdx)) begin
        value_d = load_data;
      end else begin
        value_d = memArray[enterIdx];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      value_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign mem_value = value_q;
  assign mem_ready = ready_q;
  assign mem_error = error_q;

endmodule

// File: tb/tb_no_op_mem_responder.sv
// tb_no_op_mem_responder
//   Bench for no_op_mem_responder. Instance A uses LATENCY=3, instance B
//   uses LATENCY=0; both share clock, reset and the load port.
module tb_no_op_mem_responder;

  logic        clock;
  logic        reset_n;
  logic [15:0] addrA, addrB;
  logic        readA, readB;
  logic [15:0] valueA, valueB;
  logic        readyA, readyB;
  logic        errorA, errorB;
  logic        loadEn;
  logic [7:0]  loadAddr;
  logic [15:0] loadData;

  int checks;
  int passes;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        ld;
    logic [7:0]  la;
    logic [15:0] ldd;
    logic        eRdy;
    logic [15:0] eVal;
    logic        eErr;
  } vec_t;

  vec_t vecs[13];

  no_op_mem_responder #(.WIDTH(16), .DEPTH_LOG2(8), .LATENCY(3)) uDutA (
    .clock(clock), .reset_n(reset_n),
    .mem_address(addrA), .mem_read(readA),
    .mem_value(valueA), .mem_ready(readyA), .mem_error(errorA),
    .load_en(loadEn), .load_addr(loadAddr), .load_data(loadData)
  );

  no_op_mem_responder #(.WIDTH(16), .DEPTH_LOG2(8), .LATENCY(0)) uDutB (
    .clock(clock), .reset_n(reset_n),
    .mem_address(addrB), .mem_read(readB),
    .mem_value(valueB), .mem_ready(readyB), .mem_error(errorB),
    .load_en(loadEn), .load_addr(loadAddr), .load_data(loadData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of inputs to instance A (sel=0) or B (sel=1), then
  // step past the next rising edge.
  task automatic applyStimulus(input logic sel, input logic rd, input logic [15:0] addr,
                               input logic ld, input logic [7:0] la, input logic [15:0] ldd);
    if (sel) begin
      readB = rd;
      addrB = addr;
    end else begin
      readA = rd;
      addrA = addr;
    end
    loadEn   = ld;
    loadAddr = la;
    loadData = ldd;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic sel, input logic eRdy,
                             input logic [15:0] eVal, input logic eErr);
    logic        aRdy;
    logic [15:0] aVal;
    logic        aErr;
    aRdy = sel ? readyB : readyA;
    aVal = sel ? valueB : valueA;
    aErr = sel ? errorB : errorA;
    checks++;
    if (aRdy === eRdy && aVal === eVal && aErr === eErr) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: ready/value/error got %b/%h/%b expected %b/%h/%b",
               name, aRdy, aVal, aErr, eRdy, eVal, eErr);
    end
  endtask

  task automatic stepA(input string name, input logic rd, input logic [15:0] addr,
                       input logic ld, input logic [7:0] la, input logic [15:0] ldd,
                       input logic eRdy, input logic [15:0] eVal, input logic eErr);
    applyStimulus(1'b0, rd, addr, ld, la, ldd);
    checkOutput(name, 1'b0, eRdy, eVal, eErr);
  endtask

  task automatic stepB(input string name, input logic rd, input logic [15:0] addr,
                       input logic eRdy, input logic [15:0] eVal);
    applyStimulus(1'b1, rd, addr, 1'b0, 8'h00, 16'h0000);
    checkOutput(name, 1'b1, eRdy, eVal, 1'b0);
  endtask

  initial begin
    checks = 0;
    passes = 0;

    // Basic LATENCY=3 transaction: accept, 3 edges to ready, address change
    // ignored, release, request during RELEASE not accepted until IDLE.
    vecs[0]  = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h00A5, 1'b0};
    vecs[4]  = '{1'b1, 16'h0009, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h00A5, 1'b0};
    vecs[5]  = '{1'b1, 16'h0009, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h00A5, 1'b0};
    vecs[6]  = '{1'b0, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00A5, 1'b0};
    vecs[7]  = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00A5, 1'b0};
    vecs[8]  = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00A5, 1'b0};
    vecs[9]  = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00A5, 1'b0};
    vecs[10] = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00A5, 1'b0};
    vecs[11] = '{1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h00A5, 1'b0};
    vecs[12] = '{1'b0, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h00A5, 1'b0};

    reset_n  = 1'b0;
    readA    = 1'b0;
    readB    = 1'b0;
    addrA    = 16'h0000;
    addrB    = 16'h0000;
    loadEn   = 1'b0;
    loadAddr = 8'h00;
    loadData = 16'h0000;
    #12;
    checkOutput("resetA", 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("resetB", 1'b1, 1'b0, 16'h0000, 1'b0);
    #5;
    reset_n = 1'b1;

    stepA("preload05", 1'b0, 16'h0, 1'b1, 8'h05, 16'h00A5, 1'b0, 16'h0000, 1'b0);
    stepA("preload01", 1'b0, 16'h0, 1'b1, 8'h01, 16'h0011, 1'b0, 16'h0000, 1'b0);
    stepA("preload02", 1'b0, 16'h0, 1'b1, 8'h02, 16'h0022, 1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, vecs[i].rd, vecs[i].addr, vecs[i].ld, vecs[i].la, vecs[i].ldd);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].eRdy, vecs[i].eVal, vecs[i].eErr);
    end

    // LATENCY=0 back-to-back reads on instance B.
    stepB("lat0Read1",    1'b1, 16'h0001, 1'b1, 16'h0011);
    stepB("lat0Release",  1'b0, 16'h0001, 1'b0, 16'h0011);
    stepB("lat0InRel",    1'b1, 16'h0002, 1'b0, 16'h0011);
    stepB("lat0Read2",    1'b1, 16'h0002, 1'b1, 16'h0022);
    stepB("lat0Release2", 1'b0, 16'h0002, 1'b0, 16'h0022);

    // Abort during WAIT, then a fresh read completes.
    stepA("abortAcc",   1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("abortWait",  1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("abortDrop",  1'b0, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepA("abortIdle", 1'b0, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    end
    stepA("freshAcc",   1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("freshW1",    1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("freshW2",    1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("freshReady", 1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b1, 16'h00A5, 1'b0);
    stepA("freshRel",   1'b0, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("freshIdle",  1'b0, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);

    // Out-of-range address 0x101.
    stepA("oorAcc",   1'b1, 16'h0101, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("oorW1",    1'b1, 16'h0101, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("oorW2",    1'b1, 16'h0101, 1'b0, 8'h00, 16'h0, 1'b0, 16'h00A5, 1'b0);
    stepA("oorReady", 1'b1, 16'h0101, 1'b0, 8'h00, 16'h0, 1'b1, 16'h0000, 1'b1);
    stepA("oorHold",  1'b1, 16'h0101, 1'b0, 8'h00, 16'h0, 1'b1, 16'h0000, 1'b1);
    stepA("oorRel",   1'b0, 16'h0101, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    stepA("oorIdle",  1'b0, 16'h0101, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);

    // Load colliding with READY entry is write-first; later loads do not
    // disturb the held value.
    stepA("wfAcc",    1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0);
    stepA("wfW1",     1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0);
    stepA("wfW2",     1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0);
    stepA("wfEntry",  1'b1, 16'h0005, 1'b1, 8'h05, 16'h0077, 1'b1, 16'h0077, 1'b0);
    stepA("wfLate",   1'b1, 16'h0005, 1'b1, 8'h05, 16'h0099, 1'b1, 16'h0077, 1'b0);
    stepA("wfHold",   1'b1, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0077, 1'b0);
    stepA("wfRel",    1'b0, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0077, 1'b0);
    stepA("wfIdle",   1'b0, 16'h0005, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0077, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    stepA("rstWAcc",  1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0077, 1'b0);
    stepA("rstWWait", 1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0077, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("rstWAsync", 1'b0, 1'b0, 16'h0000, 1'b0);
    readA = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepA("rstWAfter", 1'b0, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    end

    // Preloaded word survives reset; then reset in the middle of READY.
    stepA("rstRAcc",   1'b1, 16'h0001, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    stepA("rstRW1",    1'b1, 16'h0001, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    stepA("rstRW2",    1'b1, 16'h0001, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    stepA("rstRReady", 1'b1, 16'h0001, 1'b0, 8'h00, 16'h0, 1'b1, 16'h0011, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("rstRAsync", 1'b0, 1'b0, 16'h0000, 1'b0);
    readA = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepA("rstRAfter", 1'b0, 16'h0001, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    end

    // Word 5 now holds 0x99 from the late load; reset did not clear it.
    stepA("postAcc",   1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    stepA("postW1",    1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    stepA("postW2",    1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0000, 1'b0);
    stepA("postReady", 1'b1, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b1, 16'h0099, 1'b0);
    stepA("postRel",   1'b0, 16'h0005, 1'b0, 8'h00, 16'h0, 1'b0, 16'h0099, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
